// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: bus field typedefs,
// owner/state enums and the streak saturation helper.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STREAK_W   = 4;

  typedef logic [ADDR_W_DEF-1:0]   addr_t;
  typedef logic [DATA_W_DEF-1:0]   word_t;
  typedef logic [DATA_W_DEF/8-1:0] strb_t;
  typedef logic [STREAK_W-1:0]     streak_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} mem_owner_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} arb_state_e;

  function automatic streak_t streak_sat_inc(input streak_t s, input streak_t max);
    return (s >= max) ? max : s + streak_t'(1);
  endfunction

endpackage

// File: rtl/mem_port_prio.sv
// Owner selection between fetch and load/store, with a streak counter that
// forces a fetch grant after too many consecutive data grants.
module mem_port_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       if_pend,
  input  logic       d_pend,
  output mem_owner_e owner
);

  localparam streak_t STREAK_MAX = streak_t'(MAX_DATA_STREAK);

  streak_t streak_reg;
  streak_t streak_next;

  always_comb begin
    owner = OWN_NONE;
    if (d_pend && !(if_pend && (streak_reg == STREAK_MAX))) begin
      owner = OWN_MEM;
    end else if (if_pend) begin
      owner = OWN_IF;
    end
  end

  // Only data grants taken while fetch is waiting count toward the streak.
  always_comb begin
    streak_next = streak_reg;
    if (!if_pend) begin
      streak_next = '0;
    end else if (sel && (owner == OWN_IF)) begin
      streak_next = '0;
    end else if (sel && (owner == OWN_MEM)) begin
      streak_next = streak_sat_inc(streak_reg, STREAK_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Time-multiplexes one memory port between instruction fetch and load/store,
// one transaction at a time, and reports per-requester stalls.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_reg;
  arb_state_e          state_next;
  mem_owner_e          owner_reg;
  mem_owner_e          pick;
  logic                kill_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic                sel;
  logic                rsp_fire;
  logic                flush_hit;

  assign sel       = (state_reg == ST_IDLE) && (if_req || d_req);
  assign rsp_fire  = (state_reg == ST_RSP) && mem_rvalid;
  assign flush_hit = if_flush && (owner_reg == OWN_IF) &&
                     ((state_reg == ST_REQ) || (state_reg == ST_RSP));

  mem_port_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .if_pend(if_req),
    .d_pend (d_req),
    .owner  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (if_req || d_req) state_next = ST_REQ;
      ST_REQ:  if (mem_gnt)         state_next = ST_RSP;
      ST_RSP:  if (mem_rvalid)      state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // A killed fetch drains on the bus but its data never reaches IF.
  always_comb begin
    mem_req   = (state_reg == ST_REQ);
    if_valid  = rsp_fire && (owner_reg == OWN_IF) && !kill_reg && !if_flush;
    d_valid   = rsp_fire && (owner_reg == OWN_MEM);
    if_rdata  = if_valid ? mem_rdata : '0;
    d_rdata   = d_valid ? mem_rdata : '0;
    stall_if  = if_req && !if_valid;
    stall_mem = d_req && !d_valid;
  end

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = wstrb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg <= OWN_NONE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      kill_reg  <= 1'b0;
    end else begin
      if (sel) begin
        owner_reg <= pick;
        we_reg    <= (pick == OWN_MEM) && d_we;
        addr_reg  <= (pick == OWN_MEM) ? d_addr : if_addr;
      end else if (rsp_fire) begin
        owner_reg <= OWN_NONE;
      end
      if (rsp_fire) begin
        kill_reg <= 1'b0;
      end else if (flush_hit) begin
        kill_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wdata_reg[8*gi +: 8] <= '0;
        wstrb_reg[gi]        <= 1'b0;
      end else if (sel) begin
        wdata_reg[8*gi +: 8] <= (pick == OWN_MEM) ? d_wdata[8*gi +: 8] : 8'h00;
        wstrb_reg[gi]        <= (pick == OWN_MEM) && d_wstrb[gi];
      end
    end
  end

  a_gnt_state: assert property (@(posedge clk) disable iff (!rst_n)
    mem_gnt |-> (state_reg == ST_REQ));
  a_rvalid_state: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rvalid |-> (state_reg == ST_RSP));
  a_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_valid && d_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: requester drivers, a small memory model and a scoreboard of
// expected bus issues and responses.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic  we;
    addr_t addr;
    word_t wdata;
    strb_t strb;
  } bus_t;

  typedef struct {
    logic  is_if;
    word_t data;
    logic  chk_data;
  } rsp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  if_req, if_flush, d_req, d_we;
  addr_t if_addr, d_addr;
  word_t d_wdata;
  strb_t d_wstrb;
  word_t if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic  if_valid, d_valid, mem_req, mem_we, mem_gnt, mem_rvalid;
  addr_t mem_addr;
  strb_t mem_wstrb;
  logic  stall_if, stall_mem;

  bus_t  bus_q[$];
  bus_t  d_todo[$];
  rsp_t  rsp_q[$];
  addr_t if_todo[$];
  int    checks = 0;
  int    errors = 0;
  int    stall_cnt = 0;
  int    valid_cnt = 0;
  int    rsp_lat = 1;

  word_t mem_arr [addr_t];
  logic  pend;
  int    cnt;
  word_t held;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  assign mem_gnt = mem_req;

  function automatic word_t rd_word(input addr_t a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  // Memory: accepts in the grant cycle, answers rsp_lat cycles later.
  always @(posedge clk or negedge rst_n) begin
    word_t v;
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      pend       <= 1'b0;
      cnt        <= 0;
      held       <= '0;
    end else begin
      mem_rvalid <= 1'b0;
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          v = rd_word(mem_addr);
          for (int i = 0; i < 4; i++)
            if (mem_wstrb[i]) v[8*i +: 8] = mem_wdata[8*i +: 8];
          mem_arr[mem_addr] = v;
          v = 32'hBAD0BAD0;
        end else begin
          v = rd_word(mem_addr);
        end
        if (rsp_lat <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= v;
        end else begin
          pend <= 1'b1;
          cnt  <= rsp_lat - 2;
          held <= v;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= held;
          pend       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bus_t b;
    rsp_t r;
    logic ifd, dd;
    @(negedge clk);
    if (stall_if) stall_cnt++;
    if (mem_req && mem_gnt) begin
      $display("bus  we=%0b addr=%08h wdata=%08h wstrb=%04b", mem_we, mem_addr, mem_wdata, mem_wstrb);
      chk("bus_expected", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() != 0) begin
        b = bus_q.pop_front();
        chk("bus_we", 32'(mem_we), 32'(b.we));
        chk("bus_addr", mem_addr, b.addr);
        chk("bus_wdata", mem_wdata, b.wdata);
        chk("bus_wstrb", 32'(mem_wstrb), 32'(b.strb));
      end
    end
    if (if_valid || d_valid) begin
      valid_cnt++;
      $display("rsp  if_valid=%0b if_rdata=%08h d_valid=%0b d_rdata=%08h", if_valid, if_rdata, d_valid, d_rdata);
      chk("valid_excl", 32'(if_valid && d_valid), 32'd0);
      chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("rsp_src", 32'(if_valid), 32'(r.is_if));
        if (r.chk_data) chk("rsp_data", if_valid ? if_rdata : d_rdata, r.data);
      end
    end
    ifd = if_valid;
    dd  = d_valid;
    @(posedge clk);
    #1;
    if (ifd || !if_req) begin
      if (if_todo.size() != 0) begin
        if_addr = if_todo.pop_front();
        if_req  = 1'b1;
      end else begin
        if_req = 1'b0;
      end
    end
    if (dd || !d_req) begin
      if (d_todo.size() != 0) begin
        b = d_todo.pop_front();
        d_we = b.we; d_addr = b.addr; d_wdata = b.wdata; d_wstrb = b.strb;
        d_req = 1'b1;
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && ((bus_q.size() + rsp_q.size() + if_todo.size() + d_todo.size()) != 0 || if_req || d_req)) begin
      step();
      n++;
    end
    chk(tag, 32'(bus_q.size() + rsp_q.size()), 32'd0);
  endtask

  task automatic push_fetch(input addr_t a, input word_t data);
    if_todo.push_back(a);
    bus_q.push_back('{we: 1'b0, addr: a, wdata: '0, strb: '0});
    rsp_q.push_back('{is_if: 1'b1, data: data, chk_data: 1'b1});
  endtask

  task automatic push_load(input addr_t a, input word_t data);
    d_todo.push_back('{we: 1'b0, addr: a, wdata: '0, strb: '0});
    bus_q.push_back('{we: 1'b0, addr: a, wdata: '0, strb: '0});
    rsp_q.push_back('{is_if: 1'b0, data: data, chk_data: 1'b1});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_stall_if"}, 32'(stall_if), 32'd0);
    chk({tag, "_stall_mem"}, 32'(stall_mem), 32'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Lone fetch; response one cycle after the first RSP cycle.
    rsp_lat = 2;
    stall_cnt = 0;
    push_fetch(32'h100, 32'hDEADBEEF);
    drain("fetch_only", 30);
    chk("fetch_stall_cycles", 32'(stall_cnt), 32'd3);

    // Simultaneous fetch and load: load first, stall_if held across both.
    rsp_lat = 1;
    stall_cnt = 0;
    d_todo.push_back('{we: 1'b0, addr: 32'h200, wdata: '0, strb: '0});
    if_todo.push_back(32'h104);
    bus_q.push_back('{we: 1'b0, addr: 32'h200, wdata: '0, strb: '0});
    bus_q.push_back('{we: 1'b0, addr: 32'h104, wdata: '0, strb: '0});
    rsp_q.push_back('{is_if: 1'b0, data: ~32'h200, chk_data: 1'b1});
    rsp_q.push_back('{is_if: 1'b1, data: ~32'h104, chk_data: 1'b1});
    drain("same_cycle", 30);
    chk("same_cycle_stall_cycles", 32'(stall_cnt), 32'd5);

    // Six back-to-back loads against a waiting fetch: M,M,M,M,I,M,M.
    if_todo.push_back(32'h108);
    for (int i = 0; i < 6; i++)
      d_todo.push_back('{we: 1'b0, addr: 32'h600 + 32'(4*i), wdata: '0, strb: '0});
    for (int i = 0; i < 7; i++) begin
      base = (i < 4) ? i : i - 1;
      if (i == 4) begin
        bus_q.push_back('{we: 1'b0, addr: 32'h108, wdata: '0, strb: '0});
        rsp_q.push_back('{is_if: 1'b1, data: ~32'h108, chk_data: 1'b1});
      end else begin
        bus_q.push_back('{we: 1'b0, addr: 32'h600 + 32'(4*base), wdata: '0, strb: '0});
        rsp_q.push_back('{is_if: 1'b0, data: ~(32'h600 + 32'(4*base)), chk_data: 1'b1});
      end
    end
    drain("streak", 80);

    // Partial store then read-back of the merged word.
    d_todo.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'h12345678, strb: 4'b0011});
    bus_q.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'h12345678, strb: 4'b0011});
    rsp_q.push_back('{is_if: 1'b0, data: '0, chk_data: 1'b0});
    push_load(32'h40, 32'hFFFF5678);
    drain("store", 30);

    // Flush while the fetch sits in RSP; redirected fetch follows the drain.
    rsp_lat = 3;
    if_todo.push_back(32'h500);
    bus_q.push_back('{we: 1'b0, addr: 32'h500, wdata: '0, strb: '0});
    for (int n = 0; n < 20 && bus_q.size() != 0; n++) step();
    chk("flush_first_issued", 32'(bus_q.size()), 32'd0);
    if_flush = 1'b1;
    if_addr  = 32'h300;
    rsp_lat  = 1;
    bus_q.push_back('{we: 1'b0, addr: 32'h300, wdata: '0, strb: '0});
    rsp_q.push_back('{is_if: 1'b1, data: ~32'h300, chk_data: 1'b1});
    step();
    if_flush = 1'b0;
    valid_cnt = 0;
    drain("flush", 30);
    chk("flush_valid_count", 32'(valid_cnt), 32'd1);

    // Reset while a fetch is in RSP.
    rsp_lat = 3;
    if_todo.push_back(32'h700);
    bus_q.push_back('{we: 1'b0, addr: 32'h700, wdata: '0, strb: '0});
    for (int n = 0; n < 20 && bus_q.size() != 0; n++) step();
    chk("rst_fetch_issued", 32'(bus_q.size()), 32'd0);
    #3;
    rst_n  = 1'b0;
    if_req = 1'b0;
    if_todo.delete();
    rsp_q.delete();
    #1;
    check_idle_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid_cnt = 0;
    repeat (6) step();
    chk("no_late_valid", 32'(valid_cnt), 32'd0);
    rsp_lat = 1;
    push_fetch(32'h100, 32'hDEADBEEF);
    drain("after_reset", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the load/store stage (MEM).
- Resolves the IF/MEM structural hazard in time instead of by duplicating the memory.
- Issues one transaction at a time and returns per-requester stall signals, which the pipeline ORs with the HazardUnit stall.
- Fetch requests can be flushed after a taken branch.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width; DATA_W/8 byte strobes.
- MAX_DATA_STREAK, 4, number of consecutive MEM grants allowed while IF is waiting; the next grant is then forced to IF. Range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_flush  in  1  one-cycle pulse: discard the current fetch.
- if_rdata  out  DATA_W  fetched word.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle pulse: load data or store ack.
- mem_req  out  1  memory request.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  request fields.
- mem_gnt  in  1  request accepted this cycle (mem_req && mem_gnt).
- mem_rvalid  in  1  response: read data or write ack.
- mem_rdata  in  DATA_W  read data.
- stall_if  out  1  IF must hold.
- stall_mem  out  1  MEM and earlier stages must hold.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; owner = NONE; streak = 0; kill = 0.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: mem_req high, waiting for mem_gnt.
  - RSP: waiting for mem_rvalid.
- IDLE transition: on any request, pick an owner and go to REQ on the next edge. The request fields are registered at selection and held stable until mem_gnt.
- Owner selection:
  - MEM wins over IF unless IF is pending and streak == MAX_DATA_STREAK; then IF wins.
  - streak increments on each MEM grant while if_req is high (saturates at MAX_DATA_STREAK).
  - streak clears on an IF grant or when if_req is low.
- REQ transition: on mem_gnt go to RSP. Requester inputs are not re-sampled.
- RSP transition: on mem_rvalid, route mem_rdata to the owner's rdata and pulse its valid for one cycle, then go to IDLE.
- Back-to-back: the next selection can happen in the IDLE cycle right after the response. Minimum occupancy is 3 cycles per transaction with zero-wait memory.
- if_valid and d_valid are never high in the same cycle.
- stall_if = if_req && !if_valid. stall_mem = d_req && !d_valid. Both are combinational.
- Flush:
  - if_flush while IF owns REQ or RSP sets kill. The transaction still completes on the bus. A store is never cancelled, and the fetch is never withdrawn after mem_req.
  - On response with kill set: if_valid is suppressed, kill clears, and the FSM returns to IDLE.
  - if_flush in IDLE, or while MEM owns the bus, has no effect on arbitration. IF re-requests with the new address.
- A flush and a new if_req in the same cycle are legal. The new fetch is arbitrated after the killed one drains.
- mem_gnt or mem_rvalid arriving in an unexpected state is ignored and flagged by an assertion.
- Reset mid-transaction: immediate return to reset state. The memory shares rst_n, so nothing is left outstanding.

Decomposition:
- Shared package additions:
  - Addr and Word typedefs.
  - Strobe typedef.
  - MemOwner enum {NONE, IF, MEM}.
  - ArbState enum {IDLE, REQ, RSP}.
- Sub-module mem_port_prio: combinational owner selection plus the streak counter register.

Test Plan:
- Only IF requests addr 0x100, memory gnt on first cycle, rvalid one cycle later with 0xDEADBEEF -> mem_addr=0x100, if_valid pulse with 0xDEADBEEF, stall_if high for 3 cycles.
- IF and MEM (load 0x200) requested in the same cycle -> MEM granted first, d_valid precedes if_valid, stall_if high throughout.
- IF held high while MEM issues 6 back-to-back loads, MAX_DATA_STREAK=4 -> grant order M,M,M,M,I,M,M.
- Store to 0x40, wdata 0x12345678, wstrb 0b0011 -> mem_we=1 with fields exact, d_valid on write ack, d_rdata ignored.
- IF owns RSP, if_flush pulsed, then if_req at 0x300 -> no if_valid for the first fetch, second fetch issued to 0x300 and returned.
- rst_n asserted while in RSP -> all outputs 0 asynchronously, FSM IDLE, no late valid after release.
